// File: rtl/control_unit.sv
// control_unit
//
// Purpose:
//   Main control decoder for a single-issue RISC-V datapath. It turns the
//   7-bit major opcode into the seven datapath control signals. Every
//   control bit is registered, so the outputs show the decode of the
//   opcode sampled at the previous rising clock edge. They hold steady
//   between edges no matter how OPCode moves.
//
// Ports:
//   clk      in   1  sole clock; all state changes on its rising edge
//   rst_n    in   1  synchronous active-low reset; forces every output to 0
//   OPCode   in   7  instruction bits [6:0]
//   ALUOp    out  2  00 add, 01 subtract/compare, 10 R-type funct, 11 I-type funct
//   Branch   out  1  conditional branch
//   MemRead  out  1  data-memory read enable
//   MemWrite out  1  data-memory write enable
//   MemToReg out  1  writeback select (1 = memory data, 0 = ALU result)
//   ALUSrc   out  1  operand B select (1 = immediate, 0 = rs2)
//   RegWrite out  1  register-file write enable

module control_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] OPCode,
  output logic [1:0] ALUOp,
  output logic       Branch,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemToReg,
  output logic       ALUSrc,
  output logic       RegWrite
);

  typedef enum logic [6:0] {
    OP_RTYPE  = 7'b0110011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_ITYPE  = 7'b0010011
  } opcode_e;

  logic [1:0] aluOp_d,    aluOp_q;
  logic       branch_d,   branch_q;
  logic       memRead_d,  memRead_q;
  logic       memWrite_d, memWrite_q;
  logic       memToReg_d, memToReg_q;
  logic       aluSrc_d,   aluSrc_q;
  logic       regWrite_d, regWrite_q;

  // Combinational decode. Each case item compares the full 7-bit opcode.
  // Any opcode that is not listed falls through to the all-zero NOP defaults.
  // A NOP writes no register, touches no memory and does not branch.
  always_comb begin
    aluOp_d    = 2'b00;
    branch_d   = 1'b0;
    memRead_d  = 1'b0;
    memWrite_d = 1'b0;
    memToReg_d = 1'b0;
    aluSrc_d   = 1'b0;
    regWrite_d = 1'b0;
    case (OPCode)
      OP_RTYPE: begin
        aluOp_d    = 2'b10;
        regWrite_d = 1'b1;
      end
      OP_LOAD: begin
        memRead_d  = 1'b1;
        memToReg_d = 1'b1;
        aluSrc_d   = 1'b1;
        regWrite_d = 1'b1;
      end
      OP_STORE: begin
        memWrite_d = 1'b1;
        aluSrc_d   = 1'b1;
      end
      OP_BRANCH: begin
        aluOp_d  = 2'b01;
        branch_d = 1'b1;
      end
      OP_ITYPE: begin
        aluOp_d    = 2'b11;
        aluSrc_d   = 1'b1;
        regWrite_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Output registers. Reset is sampled only at the clock edge, so it
  // overrides that edge's decode. Decoding resumes on the first edge
  // after release, with no dead cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aluOp_q    <= 2'b00;
      branch_q   <= 1'b0;
      memRead_q  <= 1'b0;
      memWrite_q <= 1'b0;
      memToReg_q <= 1'b0;
      aluSrc_q   <= 1'b0;
      regWrite_q <= 1'b0;
    end else begin
      aluOp_q    <= aluOp_d;
      branch_q   <= branch_d;
      memRead_q  <= memRead_d;
      memWrite_q <= memWrite_d;
      memToReg_q <= memToReg_d;
      aluSrc_q   <= aluSrc_d;
      regWrite_q <= regWrite_d;
    end
  end

  assign ALUOp    = aluOp_q;
  assign Branch   = branch_q;
  assign MemRead  = memRead_q;
  assign MemWrite = memWrite_q;
  assign MemToReg = memToReg_q;
  assign ALUSrc   = aluSrc_q;
  assign RegWrite = regWrite_q;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit
//
// Purpose:
//   Self-checking bench for control_unit. It drives directed and random
//   opcode/reset sequences. Each registered output vector is compared with
//   a reference taken from the decode table. Control vectors are packed as
//   {ALUOp[1:0], Branch, MemRead, MemWrite, MemToReg, ALUSrc, RegWrite}.
//
// Ports: none (top-level bench).

module tb_control_unit;

  logic       clk;
  logic       rst_n;
  logic [6:0] OPCode;
  logic [1:0] ALUOp;
  logic       Branch;
  logic       MemRead;
  logic       MemWrite;
  logic       MemToReg;
  logic       ALUSrc;
  logic       RegWrite;

  int checks;
  int errors;

  control_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .OPCode   (OPCode),
    .ALUOp    (ALUOp),
    .Branch   (Branch),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .MemToReg (MemToReg),
    .ALUSrc   (ALUSrc),
    .RegWrite (RegWrite)
  );

  // 10 ns clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stops a runaway simulation. It prints a FAIL line first.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference decode. It looks the opcode up in a five-entry table.
  // Any opcode that is not in the table gives the all-zero NOP vector.
  function automatic logic [7:0] refCtrl(input logic [6:0] op);
    logic [6:0] ops [5];
    logic [7:0] ctl [5];
    ops = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011};
    ctl = '{8'b10_000001, 8'b00_010111, 8'b00_001010, 8'b01_100000, 8'b11_000011};
    refCtrl = 8'h00;
    for (int k = 0; k < 5; k++)
      if (op == ops[k]) refCtrl = ctl[k];
  endfunction

  function automatic logic [7:0] observed();
    return {ALUOp, Branch, MemRead, MemWrite, MemToReg, ALUSrc, RegWrite};
  endfunction

  // Drives the inputs straight away. The caller chooses when this happens
  // relative to the clock.
  task automatic applyStimulus(input logic rst, input logic [6:0] op);
    rst_n  = rst;
    OPCode = op;
  endtask

  // Moves to 1 ns after the next rising edge, so outputs are sampled away
  // from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] expected);
    logic [7:0] obs;
    obs = observed();
    checks++;
    assert (obs === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, expected);
    end
  endtask

  task automatic checkFlag(input string tag, input logic obs, input logic expected);
    checks++;
    assert (obs === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, expected);
    end
  endtask

  initial begin
    logic [6:0] op;
    logic       rst;
    logic [6:0] tableOps [5];
    int         nonzeroCount;
    checks = 0;
    errors = 0;
    tableOps = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011};

    // Reset held for two edges while an R-type opcode is present.
    applyStimulus(1'b0, 7'b0110011);
    tick();
    checkOutput("reset_edge1", 8'h00);
    tick();
    checkOutput("reset_edge2", 8'h00);

    // Back-to-back table opcodes. Each decode shows after exactly one edge.
    applyStimulus(1'b1, 7'b0110011);
    tick();
    checkOutput("rtype", refCtrl(7'b0110011));
    applyStimulus(1'b1, 7'b0000011);
    tick();
    checkOutput("load", refCtrl(7'b0000011));
    applyStimulus(1'b1, 7'b0100011);
    tick();
    checkOutput("store", refCtrl(7'b0100011));
    applyStimulus(1'b1, 7'b1100011);
    tick();
    checkOutput("branch", refCtrl(7'b1100011));
    applyStimulus(1'b1, 7'b0010011);
    tick();
    checkOutput("itype", refCtrl(7'b0010011));

    // Opcodes outside the table decode to NOP.
    applyStimulus(1'b1, 7'b0000000);
    tick();
    checkOutput("nop_zero", 8'h00);
    applyStimulus(1'b1, 7'b1111111);
    tick();
    checkOutput("nop_ones", 8'h00);
    applyStimulus(1'b1, 7'b0110111);
    tick();
    checkOutput("nop_lui", 8'h00);

    // An opcode change in mid-cycle must not show until the next edge.
    applyStimulus(1'b1, 7'b0000011);
    tick();
    checkOutput("hold_load", refCtrl(7'b0000011));
    #2 applyStimulus(1'b1, 7'b0100011);
    #1 checkOutput("hold_midcycle", refCtrl(7'b0000011));
    tick();
    checkOutput("hold_store", refCtrl(7'b0100011));

    // Reset asserted between edges takes effect only at the next edge.
    // Decoding resumes on the first edge after release.
    applyStimulus(1'b1, 7'b0000011);
    tick();
    checkOutput("rst_mid_load", refCtrl(7'b0000011));
    #2 applyStimulus(1'b0, 7'b0000011);
    #1 checkOutput("rst_mid_before_edge", refCtrl(7'b0000011));
    tick();
    checkOutput("rst_mid_after_edge", 8'h00);
    applyStimulus(1'b1, 7'b1100011);
    tick();
    checkOutput("rst_release_branch", refCtrl(7'b1100011));

    // Sweep all 128 opcodes. Checks each decode and the exclusivity rules,
    // and counts how many opcodes give a nonzero vector.
    nonzeroCount = 0;
    for (int i = 0; i < 128; i++) begin
      op = 7'(i);
      applyStimulus(1'b1, op);
      tick();
      checkOutput($sformatf("sweep_%02h", op), refCtrl(op));
      checkFlag($sformatf("sweep_rd_wr_%02h", op), MemRead & MemWrite, 1'b0);
      checkFlag($sformatf("sweep_rw_wr_%02h", op), RegWrite & MemWrite, 1'b0);
      if (observed() !== 8'h00) nonzeroCount++;
    end
    checks++;
    assert (nonzeroCount == 5) else begin
      errors++;
      $error("[TB] FAIL sweep_nonzero_count: observed=%0d expected=%0d", nonzeroCount, 5);
    end

    // Random run. Opcodes are biased towards table entries and reset is
    // asserted now and then.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 1) == 1)
        op = tableOps[$urandom_range(0, 4)];
      else
        op = 7'($urandom_range(0, 127));
      applyStimulus(rst, op);
      tick();
      checkOutput($sformatf("random_%0d_op%02h_rst%0b", i, op, rst),
                  rst ? refCtrl(op) : 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
